// File: rtl/t3_compare_arb.sv
// Round-robin arbiter that shares one balanced-ternary comparator among NREQ requesters.
// The winner's operands are latched, compared in CMP, and the registered result is shown in DONE.

module t3_compare #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       res,
  output logic             bad
);

  // Trit order for comparison: -1 (01) < 0 (00) < +1 (10).
  function automatic logic [1:0] rank(input logic [1:0] t);
    case (t)
      2'b01:   rank = 2'd0;
      2'b00:   rank = 2'd1;
      2'b10:   rank = 2'd2;
      default: rank = 2'd3;
    endcase
  endfunction

  logic decided;

  always_comb begin
    res     = 2'b00;
    bad     = 1'b0;
    decided = 1'b0;
    for (int t = WIDTH/2 - 1; t >= 0; t--) begin
      if (a[2*t +: 2] == 2'b11 || b[2*t +: 2] == 2'b11) begin
        bad = 1'b1;
      end
      if (!decided && a[2*t +: 2] != b[2*t +: 2]) begin
        decided = 1'b1;
        res     = (rank(a[2*t +: 2]) > rank(b[2*t +: 2])) ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

module t3_compare_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic [NREQ-1:0]       I_req,
  input  logic [NREQ*WIDTH-1:0] I_a,
  input  logic [NREQ*WIDTH-1:0] I_b,
  output logic [NREQ-1:0]       O_gnt,
  output logic [NREQ-1:0]       O_valid,
  output logic [1:0]            O_out,
  output logic                  O_bad,
  output logic                  O_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [PW-1:0]     ptr_reg;
  logic [PW-1:0]     own_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [NREQ-1:0]   gnt_reg;
  logic [NREQ-1:0]   valid_reg;
  logic [1:0]        out_reg;
  logic              bad_reg;

  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = I_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = I_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan downward so the requester closest to ptr is the last (winning) assignment.
  logic          found;
  logic [PW-1:0] win;
  int            idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (I_req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  logic [1:0] cmp_res;
  logic       cmp_bad;

  t3_compare #(.WIDTH(WIDTH)) u_cmp (
    .a   (a_reg),
    .b   (b_reg),
    .res (cmp_res),
    .bad (cmp_bad)
  );

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      own_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      gnt_reg   <= '0;
      valid_reg <= '0;
      out_reg   <= 2'b00;
      bad_reg   <= 1'b0;
    end else begin
      gnt_reg   <= '0;
      valid_reg <= '0;
      case (state_reg)
        IDLE, DONE: begin
          if (found) begin
            a_reg     <= a_arr[win];
            b_reg     <= b_arr[win];
            own_reg   <= win;
            gnt_reg   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            state_reg <= CMP;
          end else begin
            state_reg <= IDLE;
          end
        end
        CMP: begin
          out_reg   <= cmp_bad ? 2'b00 : cmp_res;
          bad_reg   <= cmp_bad;
          valid_reg <= {{(NREQ-1){1'b0}}, 1'b1} << own_reg;
          ptr_reg   <= (own_reg == PW'(NREQ - 1)) ? '0 : own_reg + 1'b1;
          state_reg <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign O_gnt   = gnt_reg;
  assign O_valid = valid_reg;
  assign O_out   = out_reg;
  assign O_bad   = bad_reg;
  assign O_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_t3_compare_arb.sv
// Directed self-checking bench for t3_compare_arb: latency, round-robin order, illegal trits, reset abort.

module tb_t3_compare_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  I_clk;
  logic                  I_rst;
  logic [NREQ-1:0]       I_req;
  logic [NREQ*WIDTH-1:0] I_a;
  logic [NREQ*WIDTH-1:0] I_b;
  logic [NREQ-1:0]       O_gnt;
  logic [NREQ-1:0]       O_valid;
  logic [1:0]            O_out;
  logic                  O_bad;
  logic                  O_busy;

  int n_checks;
  int n_pass;

  t3_compare_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .I_req   (I_req),
    .I_a     (I_a),
    .I_b     (I_b),
    .O_gnt   (O_gnt),
    .O_valid (O_valid),
    .O_out   (O_out),
    .O_bad   (O_bad),
    .O_busy  (O_busy)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic do_reset();
    I_rst = 1'b1;
    I_req = '0;
    step();
    step();
    I_rst = 1'b0;
  endtask

  task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b);
    I_a[r*WIDTH +: WIDTH] = a;
    I_b[r*WIDTH +: WIDTH] = b;
  endtask

  // Single requester from IDLE: grant at T+1, result at T+2, idle again at T+3.
  task automatic run_one(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] exp_out, input logic exp_bad);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    set_ops(r, a, b);
    I_req[r] = 1'b1;
    step();
    check({tag, " gnt"}, 32'(O_gnt), 32'(oh));
    check({tag, " busy_cmp"}, 32'(O_busy), 32'd1);
    I_req[r] = 1'b0;
    step();
    check({tag, " valid"}, 32'(O_valid), 32'(oh));
    check({tag, " gnt_off"}, 32'(O_gnt), 32'd0);
    check({tag, " out"}, 32'(O_out), 32'(exp_out));
    check({tag, " bad"}, 32'(O_bad), 32'(exp_bad));
    step();
    check({tag, " idle"}, 32'({O_busy, O_valid, O_gnt}), 32'd0);
    $display("txn %s: req%0d a=%08h b=%08h out=%b bad=%b", tag, r, a, b, O_out, O_bad);
  endtask

  logic [1:0]      exp4 [4];
  int              fair [4];
  logic [NREQ-1:0] oh;
  int              w;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    I_rst    = 1'b1;
    I_req    = '0;
    I_a      = '0;
    I_b      = '0;

    // Reset state
    do_reset();
    check("rst gnt", 32'(O_gnt), 32'd0);
    check("rst valid", 32'(O_valid), 32'd0);
    check("rst out", 32'(O_out), 32'd0);
    check("rst bad", 32'(O_bad), 32'd0);
    check("rst busy", 32'(O_busy), 32'd0);

    // Basic latency, equal operands
    run_one("eq4", 0, 32'h4, 32'h4, 2'b00, 1'b0);

    // All four request at once
    do_reset();
    set_ops(0, 32'h0,   32'h2);
    set_ops(1, 32'h0,   32'h1);
    set_ops(2, 32'hAAA, 32'h2AA);
    set_ops(3, 32'h6AA, 32'h2AA);
    exp4[0] = 2'b01; exp4[1] = 2'b10; exp4[2] = 2'b10; exp4[3] = 2'b01;
    I_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      oh = '0;
      oh[i] = 1'b1;
      step();
      check($sformatf("all gnt%0d", i), 32'(O_gnt), 32'(oh));
      I_req[i] = 1'b0;
      step();
      check($sformatf("all valid%0d", i), 32'(O_valid), 32'(oh));
      check($sformatf("all out%0d", i), 32'(O_out), 32'(exp4[i]));
      $display("txn all: req%0d out=%b", i, O_out);
    end
    step();
    check("all idle", 32'(O_busy), 32'd0);

    // Fairness between two persistent requesters
    do_reset();
    set_ops(0, 32'h0, 32'h0);
    set_ops(2, 32'h0, 32'h0);
    fair[0] = 0; fair[1] = 2; fair[2] = 0; fair[3] = 2;
    I_req = 4'b0101;
    step();
    for (int i = 0; i < 4; i++) begin
      oh = '0;
      oh[fair[i]] = 1'b1;
      check($sformatf("fair gnt%0d", i), 32'(O_gnt), 32'(oh));
      w = fair[i];
      I_req[w] = 1'b0;
      step();
      check($sformatf("fair valid%0d", i), 32'(O_valid), 32'(oh));
      $display("txn fair: grant %0d to req%0d", i, w);
      step();
      I_req[w] = 1'b1;
    end
    I_req = '0;

    // Illegal code, then a legal compare clears the flag
    do_reset();
    run_one("illegal", 1, 32'h3, 32'h0, 2'b00, 1'b1);
    run_one("legal", 2, 32'h0, 32'h2, 2'b01, 1'b0);

    // Reset during CMP abandons the transaction and restores ptr to 0
    do_reset();
    run_one("pre", 1, 32'h0, 32'h2, 2'b01, 1'b0);
    set_ops(2, 32'h2, 32'h0);
    I_req[2] = 1'b1;
    step();
    check("abort gnt", 32'(O_gnt), 32'b0100);
    I_req = '0;
    I_rst = 1'b1;
    step();
    I_rst = 1'b0;
    check("abort outs", 32'({O_gnt, O_valid, O_out, O_bad, O_busy}), 32'd0);
    step();
    check("abort no valid", 32'(O_valid), 32'd0);
    set_ops(1, 32'h0, 32'h0);
    set_ops(3, 32'h0, 32'h0);
    I_req = 4'b1010;
    step();
    check("abort ptr0 gnt", 32'(O_gnt), 32'b0010);
    $display("txn abort: post-reset grant=%b", O_gnt);
    I_req = '0;
    step();
    step();

    // Extremes
    run_one("pos_vs_neg", 0, 32'hAAAAAAAA, 32'h55555555, 2'b10, 1'b0);
    run_one("neg_vs_pos", 0, 32'h55555555, 32'hAAAAAAAA, 2'b01, 1'b0);
    run_one("pos_eq", 0, 32'hAAAAAAAA, 32'hAAAAAAAA, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/t3_compare_arb.md
# t3_compare_arb

Shared-resource arbiter for the balanced-ternary comparator `t3_compare`. It accepts compare requests from `NREQ` requesters, picks one round-robin, latches that requester's operand pair, and runs it through a single registered `t3_compare` instance. It returns the 2-bit ordering result to the winning requester with a one-hot valid pulse. It sits between the ternary ALU/branch units and the one comparator they share.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; 2..8.
- `WIDTH`, 32: operand width in bits; even; `WIDTH/2` trits, 2 bits per trit.

Ports:
- `I_clk`  in  1  clock. One clock domain; all logic on the rising edge.
- `I_rst`  in  1  reset. Synchronous, active-high.
- `I_req`  in  NREQ  per-requester request level.
- `I_a`  in  NREQ*WIDTH  operand A of each requester; requester i uses bits [i*WIDTH +: WIDTH].
- `I_b`  in  NREQ*WIDTH  operand B of each requester; same packing as `I_a`.
- `O_gnt`  out  NREQ  one-hot, one-cycle pulse. The cycle after the winner's operands are captured.
- `O_valid`  out  NREQ  one-hot, one-cycle pulse. Result for that requester is on `O_out`/`O_bad`.
- `O_out`  out  2  result. 00 means a==b, 01 means a<b, 10 means a>b.
- `O_bad`  out  1  a captured operand contained the illegal trit code 11.
- `O_busy`  out  1  high in CMP and DONE.

## Operation
- Trit encoding: 00 is 0, 01 is −1, 10 is +1, 11 is illegal. Trit 0 is bits [1:0]; the most significant trit decides the result.
- State register values: IDLE, CMP, DONE. There is a round-robin pointer `ptr` in 0..NREQ-1 and an owner index `own`.
- Arbitration (from IDLE, or from DONE):
  - The winner `w` is the first set bit of `I_req` scanning from `ptr` upward, wrapping.
  - At the edge: latch a_w and b_w, set `own<=w`, `O_gnt<=onehot(w)`, `state<=CMP`.
  - If no request is present: IDLE stays IDLE; DONE goes to IDLE.
- CMP:
  - `O_gnt` is high for this cycle only.
  - The comparator evaluates the latched operands combinationally.
  - At the edge: register the result into `O_out` and the illegal-code flag into `O_bad`. If `O_bad` is set, force `O_out` to 00.
  - Also at the edge: `ptr<=(own+1) mod NREQ`, `state<=DONE`.
- DONE:
  - `O_valid[own]=1`; `O_out`/`O_bad` are valid.
  - Arbitration runs in this same cycle using the updated `ptr`.
- Requester rule:
  - Hold `I_req[i]`, `I_a`, `I_b` stable until `O_gnt[i]` is seen.
  - `I_req[i]` must be low in the cycle after `O_gnt[i]` (the DONE cycle); otherwise it is treated as a new request.
  - Operands are not sampled again after capture.
- `O_out`/`O_bad` hold their last value outside DONE. They are meaningful only together with `O_valid`.
- `I_req` bits for indices ≥ NREQ do not exist. A requester dropping `I_req` before grant is simply not selected.

## Timing
- Reset (at a clock edge with `I_rst=1`):
  - state=IDLE, `ptr`=0, `own`=0.
  - `O_gnt`=0, `O_valid`=0, `O_out`=00, `O_bad`=0, `O_busy`=0.
- Reset mid-operation abandons the transaction: no `O_valid` is issued and the requester must re-request. Reset has priority over every transition.
- Latency: request present in IDLE cycle T gives `O_gnt` in cycle T+1 and `O_valid` + result in cycle T+2.
- Throughput: back-to-back requests are granted every 2 cycles (grant at T+1, T+3, …), because DONE arbitrates directly.
- Simultaneous requests:
  - Exactly one grant per arbitration.
  - After servicing i, i has lowest priority.
  - No requester waits more than NREQ−1 other grants.
- `O_gnt` and `O_valid` are never asserted in the same cycle.
- `O_gnt` and `O_valid` are zero in IDLE.

## Test plan
- After reset, req0 with a=0x4, b=0x4 → `O_gnt`=0001 at T+1; `O_valid`=0001, `O_out`=00 at T+2; `O_busy` high T+1..T+2.
- After reset, all four request at once: req0 a=0,b=0x2; req1 a=0,b=0x1; req2 a=0xAAA,b=0x2AA; req3 a=0x6AA,b=0x2AA → grants 0,1,2,3 at T+1,3,5,7; results 01,10,10,01 on the matching `O_valid`.
- Fairness: req0 re-asserts immediately after each DONE and req2 holds its request → grant order 0,2,0,2; no requester is starved.
- Illegal code: req1 a=0x3, b=0x0 → `O_valid`=0010, `O_bad`=1, `O_out`=00. The next legal compare clears `O_bad`.
- Reset mid-operation: assert `I_rst` during CMP → next cycle every output is 0 and state is IDLE. No `O_valid` for the aborted requester; the next request is granted from `ptr`=0.
- Extremes: a=0xAAAAAAAA (all +1), b=0x55555555 (all −1) → `O_out`=10; operands swapped → 01; equal → 00.
